// File: rtl/div_bcd_pkg.sv
// div_bcd_pkg
// Shared types and constants for the divider-result BCD converter.
//   state_t      : converter FSM states (IDLE, CONV, DONE), 2-bit encoded
//   bcd_digits() : BCD digit count needed to hold any unsigned value of 'width' bits
//   BCD_ADD3_THR : nibble value at or above which double-dabble adds 3
package div_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BCD_ADD3_THR = 5;

    // Every 3 binary bits need at most one decimal digit (2^3 < 10),
    // rounded up.
    function automatic int bcd_digits(input int width);
        return (width + 2) / 3;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// bcd_dabble_step
// One combinational double-dabble iteration for a single operand.
//   bcd_acc_i : current BCD accumulator (4*DIGITS bits, digit 0 in [3:0])
//   bin_sr_i  : remaining binary shift register (WIDTH bits, MSB shifts out first)
//   bcd_acc_o : accumulator after the add-3 correction and a 1-bit left shift
//   bin_sr_o  : binary shift register after the same 1-bit left shift
module bcd_dabble_step
    import div_bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic [4*DIGITS-1:0] bcd_acc_i,
    input  logic [WIDTH-1:0]    bin_sr_i,
    output logic [4*DIGITS-1:0] bcd_acc_o,
    output logic [WIDTH-1:0]    bin_sr_o
);

    localparam logic [3:0] THR = 4'(BCD_ADD3_THR);

    // A nibble >= 5 would become >= 10 after doubling; adding 3 first makes
    // the shift carry into the next digit exactly as decimal doubling would.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= THR) ? nib + 4'd3 : nib;
    endfunction

    logic [4*DIGITS-1:0]       acc_corr;
    logic [4*DIGITS+WIDTH-1:0] joined;

    always_comb begin
        acc_corr = '0;
        for (int k = 0; k < DIGITS; k++) begin
            acc_corr[4*k +: 4] = add3(bcd_acc_i[4*k +: 4]);
        end
        // Shifting the concatenation keeps this valid for WIDTH = 1.
        joined    = {acc_corr, bin_sr_i} << 1;
        bcd_acc_o = joined[4*DIGITS+WIDTH-1 -: 4*DIGITS];
        bin_sr_o  = joined[WIDTH-1:0];
    end

endmodule

// File: rtl/div_bcd_conv.sv
// div_bcd_conv
// Converts the restoring divider's quotient and remainder to packed BCD,
// both operands in parallel, one double-dabble bit per clock.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset; aborts any conversion in flight
//   valid_in : capture strobe (divider done); accepted in IDLE or DONE
//   Q, R     : unsigned quotient / remainder, WIDTH bits each
//   busy     : high while converting (WIDTH cycles)
//   q_bcd    : quotient BCD, digit k in [4k+3:4k], k=0 units
//   r_bcd    : remainder BCD, same packing
//   done     : one-cycle pulse; q_bcd/r_bcd valid from this cycle and held
//   lost     : one-cycle pulse when valid_in arrives while busy (dropped)
module div_bcd_conv
    import div_bcd_pkg::*;
#(
    parameter  int WIDTH  = 8,
    localparam int DIGITS = bcd_digits(WIDTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic [WIDTH-1:0]    Q,
    input  logic [WIDTH-1:0]    R,
    output logic                busy,
    output logic [4*DIGITS-1:0] q_bcd,
    output logic [4*DIGITS-1:0] r_bcd,
    output logic                done,
    output logic                lost
);

    localparam int              CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t state, state_nxt;

    logic [CNT_W-1:0]    cnt;
    logic [WIDTH-1:0]    q_sr, r_sr, q_sr_nxt, r_sr_nxt;
    logic [4*DIGITS-1:0] q_acc, r_acc, q_acc_nxt, r_acc_nxt;

    logic accept;
    logic finish;

    // A new capture is taken in IDLE and also in DONE for back-to-back use.
    assign accept = valid_in && ((state == IDLE) || (state == DONE));
    // The final shift happens on the same edge that enters DONE.
    assign finish = (state == CONV) && (cnt == CNT_LAST);

    bcd_dabble_step #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_step_q (
        .bcd_acc_i (q_acc),
        .bin_sr_i  (q_sr),
        .bcd_acc_o (q_acc_nxt),
        .bin_sr_o  (q_sr_nxt)
    );

    bcd_dabble_step #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_step_r (
        .bcd_acc_i (r_acc),
        .bin_sr_i  (r_sr),
        .bcd_acc_o (r_acc_nxt),
        .bin_sr_o  (r_sr_nxt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = valid_in ? CONV : IDLE;
            CONV:    state_nxt = (cnt == CNT_LAST) ? DONE : CONV;
            DONE:    state_nxt = valid_in ? CONV : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state == CONV);
        done = (state == DONE);
        // Only possible in CONV, so it can never coincide with done.
        lost = (state == CONV) && valid_in;
    end

    // Bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (state == CONV) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Working registers: no reset needed, they are always reloaded on capture.
    always_ff @(posedge clk) begin
        if (accept) begin
            q_sr  <= Q;
            r_sr  <= R;
            q_acc <= '0;
            r_acc <= '0;
        end else if (state == CONV) begin
            q_sr  <= q_sr_nxt;
            r_sr  <= r_sr_nxt;
            q_acc <= q_acc_nxt;
            r_acc <= r_acc_nxt;
        end
    end

    // Result registers: updated only on the final shift, so intermediate
    // accumulator values never appear on the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_bcd <= '0;
            r_bcd <= '0;
        end else if (finish) begin
            q_bcd <= q_acc_nxt;
            r_bcd <= r_acc_nxt;
        end
    end

endmodule

// File: tb/tb_div_bcd_conv.sv
// tb_div_bcd_conv
// Self-checking bench for div_bcd_conv (WIDTH = 8): directed scenarios from
// the test plan plus randomized operands against a decimal reference model.
module tb_div_bcd_conv;

    localparam int WIDTH  = 8;
    localparam int DIGITS = (WIDTH + 2) / 3;
    localparam int BW     = 4 * DIGITS;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid_in;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             busy;
    logic [BW-1:0]    q_bcd;
    logic [BW-1:0]    r_bcd;
    logic             done;
    logic             lost;

    int n_cmp = 0;
    int n_bad = 0;

    // Value the outputs are required to hold (last delivered result).
    logic [BW-1:0] held_q = '0;
    logic [BW-1:0] held_r = '0;

    always #5 clk = ~clk;

    div_bcd_conv #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_in (valid_in),
        .Q        (Q),
        .R        (R),
        .busy     (busy),
        .q_bcd    (q_bcd),
        .r_bcd    (r_bcd),
        .done     (done),
        .lost     (lost)
    );

    // Reference: decimal digits by repeated division.
    function automatic logic [BW-1:0] to_bcd(input int unsigned v);
        logic [BW-1:0] res;
        res = '0;
        for (int k = 0; k < DIGITS; k++) begin
            res[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return res;
    endfunction

    task automatic test_reset();
        rst = 1'b1; valid_in = 1'b0; Q = '0; R = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (lost !== 1'b0) begin n_bad++; $display("FAIL reset_lost got %b want 0", lost); end
        n_cmp++; if (q_bcd !== '0) begin n_bad++; $display("FAIL reset_q_bcd got %h want 0", q_bcd); end
        n_cmp++; if (r_bcd !== '0) begin n_bad++; $display("FAIL reset_r_bcd got %h want 0", r_bcd); end
        held_q = '0; held_r = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Called just after a rising edge. Issues one capture, optionally a
    // second strobe lost_cycle cycles into the conversion, then checks every
    // cycle through WIDTH+3 cycles: busy profile, done timing, lost, and that
    // the outputs show only the held/final value.
    task automatic test_conv(input string name, input int unsigned qv,
                             input int unsigned rv, input int lost_cycle);
        logic [BW-1:0] eq, er;
        logic exp_busy, exp_done, exp_lost;
        eq = to_bcd(qv);
        er = to_bcd(rv);
        valid_in = 1'b1; Q = WIDTH'(qv); R = WIDTH'(rv);
        @(posedge clk); #1;
        for (int c = 1; c <= WIDTH + 3; c++) begin
            if (c == lost_cycle) begin
                valid_in = 1'b1; Q = WIDTH'($urandom); R = WIDTH'($urandom);
            end else begin
                valid_in = 1'b0;
            end
            @(negedge clk);
            exp_busy = (c <= WIDTH);
            exp_done = (c == WIDTH + 1);
            exp_lost = (c == lost_cycle);
            if (exp_done) begin held_q = eq; held_r = er; end
            n_cmp++; if (busy !== exp_busy) begin n_bad++; $display("FAIL %s_busy c=%0d got %b want %b", name, c, busy, exp_busy); end
            n_cmp++; if (done !== exp_done) begin n_bad++; $display("FAIL %s_done c=%0d got %b want %b", name, c, done, exp_done); end
            n_cmp++; if (lost !== exp_lost) begin n_bad++; $display("FAIL %s_lost c=%0d got %b want %b", name, c, lost, exp_lost); end
            n_cmp++; if (q_bcd !== held_q) begin n_bad++; $display("FAIL %s_q_bcd c=%0d got %h want %h", name, c, q_bcd, held_q); end
            n_cmp++; if (r_bcd !== held_r) begin n_bad++; $display("FAIL %s_r_bcd c=%0d got %h want %h", name, c, r_bcd, held_r); end
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic exp_busy, exp_done;
        valid_in = 1'b1; Q = WIDTH'(9); R = WIDTH'(1);
        @(posedge clk); #1;
        for (int c = 1; c <= 2 * (WIDTH + 1) + 2; c++) begin
            if (c == WIDTH + 1) begin
                valid_in = 1'b1; Q = WIDTH'(10); R = WIDTH'(0);
            end else begin
                valid_in = 1'b0;
            end
            @(negedge clk);
            exp_busy = (c <= WIDTH) || (c >= WIDTH + 2 && c <= 2 * WIDTH + 1);
            exp_done = (c == WIDTH + 1) || (c == 2 * WIDTH + 2);
            if (c == WIDTH + 1)     begin held_q = to_bcd(9);  held_r = to_bcd(1); end
            if (c == 2 * WIDTH + 2) begin held_q = to_bcd(10); held_r = to_bcd(0); end
            n_cmp++; if (busy !== exp_busy) begin n_bad++; $display("FAIL b2b_busy c=%0d got %b want %b", c, busy, exp_busy); end
            n_cmp++; if (done !== exp_done) begin n_bad++; $display("FAIL b2b_done c=%0d got %b want %b", c, done, exp_done); end
            n_cmp++; if (lost !== 1'b0) begin n_bad++; $display("FAIL b2b_lost c=%0d got %b want 0", c, lost); end
            n_cmp++; if (q_bcd !== held_q) begin n_bad++; $display("FAIL b2b_q_bcd c=%0d got %h want %h", c, q_bcd, held_q); end
            n_cmp++; if (r_bcd !== held_r) begin n_bad++; $display("FAIL b2b_r_bcd c=%0d got %h want %h", c, r_bcd, held_r); end
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
    endtask

    task automatic test_reset_mid_conv();
        valid_in = 1'b1; Q = WIDTH'(200); R = WIDTH'(50);
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        held_q = '0; held_r = '0;
        for (int c = 1; c <= WIDTH + 3; c++) begin
            @(negedge clk);
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy c=%0d got %b want 0", c, busy); end
            n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done c=%0d got %b want 0", c, done); end
            n_cmp++; if (q_bcd !== '0) begin n_bad++; $display("FAIL rstmid_q_bcd c=%0d got %h want 0", c, q_bcd); end
            n_cmp++; if (r_bcd !== '0) begin n_bad++; $display("FAIL rstmid_r_bcd c=%0d got %h want 0", c, r_bcd); end
            @(posedge clk); #1;
        end
        test_conv("after_rst", 37, 5, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            test_conv("rand", $urandom_range(0, (1 << WIDTH) - 1),
                      $urandom_range(0, (1 << WIDTH) - 1),
                      ((i % 4) == 3) ? int'($urandom_range(1, WIDTH)) : 0);
        end
    endtask

    initial begin
        test_reset();
        test_conv("max_q", 255, 0, 0);
        test_conv("q100_r7", 100, 7, 0);
        test_conv("zero", 0, 0, 0);
        test_conv("lost", 42, 3, 3);
        test_back_to_back();
        test_reset_mid_conv();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
